// File: rtl/nrisc_ula_seq.sv
// nrisc_ula_seq: registered NRISC ALU with single-cycle ops and iterative
// shift-add MUL / restoring DIVU under a start/busy/done handshake.
module nrisc_ula_seq #(
   parameter int TAM = 16,
   localparam int CW = $clog2(TAM + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ULA_start,
   input  logic [3:0]     ULA_ctrl,
   input  logic [TAM-1:0] ULA_A,
   input  logic [TAM-1:0] ULA_B,
   output logic [TAM-1:0] ULA_OUT,
   output logic [TAM-1:0] ULA_OUT_HI,
   output logic [3:0]     ULA_flags,
   output logic           ULA_busy,
   output logic           ULA_done
);
   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                          OP_XOR = 4'd4, OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
                          OP_ROL = 4'd8, OP_ROR = 4'd9, OP_ADC = 4'd10, OP_SBB = 4'd11,
                          OP_MUL = 4'd12, OP_DIV = 4'd13, OP_ASR = 4'd14;
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
   state_t         st;
   logic [CW-1:0]  cnt;
   logic [TAM-1:0] acc, lo, b_r, r, nx_acc, nx_lo, div_acc;
   logic [TAM:0]   ci, add_x, sub_x, mul_s, div_s, div_d;
   logic           c, v, div_ge;
   always_comb begin
      ci = {{TAM{1'b0}}, ULA_flags[0]};
      add_x = {1'b0, ULA_A} + {1'b0, ULA_B} + (ULA_ctrl == OP_ADC ? ci : '0);
      sub_x = {1'b0, ULA_A} - {1'b0, ULA_B} - (ULA_ctrl == OP_SBB ? ci : '0);
      r = ULA_B;
      c = 1'b0;
      v = 1'b0;
      case (ULA_ctrl)
         OP_ADD, OP_ADC: begin
            r = add_x[TAM-1:0];
            c = add_x[TAM];
            v = (ULA_A[TAM-1] == ULA_B[TAM-1]) && (r[TAM-1] != ULA_A[TAM-1]);
         end
         OP_SUB, OP_SBB: begin
            r = sub_x[TAM-1:0];
            c = sub_x[TAM];
            v = (ULA_A[TAM-1] != ULA_B[TAM-1]) && (r[TAM-1] != ULA_A[TAM-1]);
         end
         OP_AND: r = ULA_A & ULA_B;
         OP_OR:  r = ULA_A | ULA_B;
         OP_XOR: r = ULA_A ^ ULA_B;
         OP_NOT: r = ~ULA_A;
         OP_SHL: begin r = {ULA_A[TAM-2:0], 1'b0}; c = ULA_A[TAM-1]; end
         OP_SHR: begin r = {1'b0, ULA_A[TAM-1:1]}; c = ULA_A[0]; end
         OP_ROL: begin r = {ULA_A[TAM-2:0], ULA_A[TAM-1]}; c = ULA_A[TAM-1]; end
         OP_ROR: begin r = {ULA_A[0], ULA_A[TAM-1:1]}; c = ULA_A[0]; end
         OP_ASR: begin r = {ULA_A[TAM-1], ULA_A[TAM-1:1]}; c = ULA_A[0]; end
         default: r = ULA_B;
      endcase
   end
   // acc holds the partial product high half / running remainder; lo shifts the multiplier out or the quotient in
   always_comb begin
      mul_s = {1'b0, acc} + (lo[0] ? {1'b0, b_r} : '0);
      div_s = {acc, lo[TAM-1]};
      div_ge = div_s >= {1'b0, b_r};
      div_d = div_s - {1'b0, b_r};
      div_acc = div_ge ? div_d[TAM-1:0] : div_s[TAM-1:0];
      nx_acc = st == S_MUL ? mul_s[TAM:1] : div_acc;
      nx_lo = st == S_MUL ? {mul_s[0], lo[TAM-1:1]} : {lo[TAM-2:0], div_ge};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         st <= S_IDLE;
         cnt <= '0;
         acc <= '0;
         lo <= '0;
         b_r <= '0;
         ULA_OUT <= '0;
         ULA_OUT_HI <= '0;
         ULA_flags <= '0;
         ULA_busy <= 1'b0;
         ULA_done <= 1'b0;
      end else begin
         ULA_done <= 1'b0;
         case (st)
            S_IDLE: begin
               if (ULA_start && (ULA_ctrl == OP_MUL || ULA_ctrl == OP_DIV)) begin
                  st <= ULA_ctrl == OP_MUL ? S_MUL : S_DIV;
                  cnt <= '0;
                  acc <= '0;
                  lo <= ULA_A;
                  b_r <= ULA_B;
                  ULA_busy <= 1'b1;
               end else if (ULA_start) begin
                  ULA_OUT <= r;
                  ULA_OUT_HI <= '0;
                  ULA_flags <= {v, r[TAM-1], r == '0, c};
                  ULA_done <= 1'b1;
               end
            end
            default: begin
               acc <= nx_acc;
               lo <= nx_lo;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(TAM - 1)) begin
                  st <= S_IDLE;
                  ULA_busy <= 1'b0;
                  ULA_done <= 1'b1;
                  ULA_OUT <= nx_lo;
                  ULA_OUT_HI <= nx_acc;
                  ULA_flags <= st == S_MUL ?
                     {1'b0, nx_acc[TAM-1], {nx_acc, nx_lo} == '0, nx_acc != '0} :
                     {1'b0, nx_lo[TAM-1], nx_lo == '0, b_r == '0};
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_nrisc_ula_seq.sv
// tb_nrisc_ula_seq: directed and randomized checks of nrisc_ula_seq against
// an arithmetic reference model.
module tb_nrisc_ula_seq;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [3:0]  ctrl = '0;
   logic [15:0] ula_a = '0, ula_b = '0, out, out_hi;
   logic [3:0]  flags;
   logic        busy, done;
   int          n_cmp = 0, n_err = 0;
   bit          mc = 1'b0;

   nrisc_ula_seq #(.TAM(16)) dut (
      .clk(clk), .rst(rst), .ULA_start(start), .ULA_ctrl(ctrl), .ULA_A(ula_a), .ULA_B(ula_b),
      .ULA_OUT(out), .ULA_OUT_HI(out_hi), .ULA_flags(flags), .ULA_busy(busy), .ULA_done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] op; logic [15:0] a, b, o, h; logic [3:0] f; logic [5:0] lat;
   } vec_t;

   function automatic void model(input int op, input int a, input int b, input bit ci,
                                 output int o, output int h, output logic [3:0] f);
      int sa, sb, s, sv, cu;
      longint p;
      bit c, v;
      sa = a >= 32768 ? a - 65536 : a;
      sb = b >= 32768 ? b - 65536 : b;
      cu = (op == 10 || op == 11) ? int'(ci) : 0;
      c = 1'b0; v = 1'b0; h = 0; o = 0; sv = 0;
      case (op)
         0, 10: begin s = a + b + cu; o = s % 65536; c = s >= 65536; sv = sa + sb + cu; v = sv > 32767 || sv < -32768; end
         1, 11: begin s = a - b - cu; o = (s + 65536) % 65536; c = s < 0; sv = sa - sb - cu; v = sv > 32767 || sv < -32768; end
         2: o = a & b;
         3: o = a | b;
         4: o = a ^ b;
         5: o = 65535 - a;
         6: begin o = (a * 2) % 65536; c = a >= 32768; end
         7: begin o = a / 2; c = a % 2 == 1; end
         8: begin o = (a * 2) % 65536 + a / 32768; c = a >= 32768; end
         9: begin o = a / 2 + (a % 2) * 32768; c = a % 2 == 1; end
         12: begin p = longint'(a) * longint'(b); o = int'(p % 65536); h = int'(p / 65536); c = h != 0; end
         13: if (b == 0) begin o = 65535; h = a; c = 1'b1; end else begin o = a / b; h = a % b; end
         14: begin o = a / 2 + (a >= 32768 ? 32768 : 0); c = a % 2 == 1; end
         default: o = b;
      endcase
      f = {v, op == 12 ? h >= 32768 : o >= 32768, op == 12 ? (o == 0 && h == 0) : o == 0, c};
   endfunction

   task automatic issue(input bit sync, input logic [3:0] op, input logic [15:0] x, input logic [15:0] y, output int lat);
      if (sync) @(negedge clk);
      ctrl = op; ula_a = x; ula_b = y; start = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      start = 1'b0;
      while (done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (out !== 16'h0 || out_hi !== 16'h0) begin n_err++; $display("FAIL reset_out: got %h/%h want 0/0", out, out_hi); end
      n_cmp++; if (flags !== 4'h0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", flags); end
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_hs: busy %b done %b want 0 0", busy, done); end
      rst = 1'b0; mc = 1'b0;
   endtask

   task automatic test_directed();
      vec_t tbl [10];
      int lat;
      tbl = '{
         '{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b1100, 6'd1},
         '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b0011, 6'd1},
         '{4'd10, 16'h0001, 16'h0001, 16'h0003, 16'h0000, 4'b0000, 6'd1},
         '{4'd1,  16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 4'b0101, 6'd1},
         '{4'd12, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 4'b0001, 6'd17},
         '{4'd13, 16'd100,  16'd7,    16'd14,   16'd2,    4'b0000, 6'd17},
         '{4'd13, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 4'b0101, 6'd17},
         '{4'd8,  16'h8001, 16'h0000, 16'h0003, 16'h0000, 4'b0001, 6'd1},
         '{4'd7,  16'h0001, 16'h0000, 16'h0000, 16'h0000, 4'b0011, 6'd1},
         '{4'd14, 16'h8000, 16'h0000, 16'hC000, 16'h0000, 4'b0100, 6'd1}};
      for (int i = 0; i < 10; i++) begin
         issue(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, lat);
         n_cmp++; if (lat != int'(tbl[i].lat)) begin n_err++; $display("FAIL dir%0d_lat: got %0d want %0d", i, lat, tbl[i].lat); end
         n_cmp++; if (out !== tbl[i].o) begin n_err++; $display("FAIL dir%0d_out: got %h want %h", i, out, tbl[i].o); end
         n_cmp++; if (out_hi !== tbl[i].h) begin n_err++; $display("FAIL dir%0d_hi: got %h want %h", i, out_hi, tbl[i].h); end
         n_cmp++; if (flags !== tbl[i].f) begin n_err++; $display("FAIL dir%0d_flags: got %b want %b", i, flags, tbl[i].f); end
         mc = tbl[i].f[0];
      end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse: got %b want 0", done); end
   endtask

   task automatic test_random(input int n, input bit chained);
      logic [3:0] op;
      logic [15:0] x, y;
      logic [3:0] ef;
      int eo, eh, lat;
      for (int i = 0; i < n; i++) begin
         op = 4'($urandom_range(0, 15));
         x = 16'($urandom);
         y = $urandom_range(0, 7) == 0 ? 16'h0 : 16'($urandom);
         model(int'(op), int'(x), int'(y), mc, eo, eh, ef);
         issue(!chained || i == 0, op, x, y, lat);
         n_cmp++; if (lat != ((op == 4'd12 || op == 4'd13) ? 17 : 1)) begin n_err++; $display("FAIL rnd%0d_lat op %0d: got %0d", i, op, lat); end
         n_cmp++; if (out !== 16'(eo) || out_hi !== 16'(eh)) begin n_err++; $display("FAIL rnd%0d_res op %0d a %h b %h: got %h/%h want %h/%h", i, op, x, y, out, out_hi, 16'(eo), 16'(eh)); end
         n_cmp++; if (flags !== ef) begin n_err++; $display("FAIL rnd%0d_flags op %0d a %h b %h c %b: got %b want %b", i, op, x, y, mc, flags, ef); end
         mc = ef[0];
      end
   endtask

   task automatic test_busy_ignore();
      int lat;
      @(negedge clk);
      ctrl = 4'd12; ula_a = 16'h1234; ula_b = 16'h0100; start = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_high: got %b want 1", busy); end
      while (done !== 1'b1 && lat < 40) begin
         if (lat == 5) begin start = 1'b1; ctrl = 4'd0; ula_a = 16'hFFFF; ula_b = 16'hFFFF; end
         else begin start = 1'b0; ula_a = 16'($urandom); ula_b = 16'($urandom); end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      n_cmp++; if (lat != 17) begin n_err++; $display("FAIL ign_lat: got %0d want 17", lat); end
      n_cmp++; if (out !== 16'h3400 || out_hi !== 16'h0012) begin n_err++; $display("FAIL ign_res: got %h/%h want 3400/0012", out, out_hi); end
      n_cmp++; if (flags !== 4'b0001 || busy !== 1'b0) begin n_err++; $display("FAIL ign_flags: got %b busy %b want 0001 0", flags, busy); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0 || out !== 16'h3400) begin n_err++; $display("FAIL ign_after: done %b out %h want 0 3400", done, out); end
      mc = 1'b1;
   endtask

   task automatic test_reset_mid();
      int lat, seen;
      @(negedge clk);
      ctrl = 4'd12; ula_a = 16'h1234; ula_b = 16'h0100; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rmid_hs: busy %b done %b want 0 0", busy, done); end
      n_cmp++; if (out !== 16'h0 || out_hi !== 16'h0 || flags !== 4'h0) begin n_err++; $display("FAIL rmid_out: got %h/%h/%b want 0", out, out_hi, flags); end
      rst = 1'b0; mc = 1'b0; seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rmid_nodone: got %0d pulses want 0", seen); end
      issue(1'b1, 4'd0, 16'h1111, 16'h2222, lat);
      n_cmp++; if (lat != 1 || out !== 16'h3333 || flags !== 4'b0000) begin n_err++; $display("FAIL rmid_add: lat %0d out %h flags %b want 1 3333 0000", lat, out, flags); end
      mc = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random(150, 1'b0);
      test_busy_ignore();
      test_random(30, 1'b1);
      test_reset_mid();
      test_random(40, 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/nrisc_ula_seq.md
Name: nrisc_ula_seq

Overview:
Parametrised, registered successor to the NRISC combinational ULA. Executes single-cycle ALU ops (add/sub with carry-in, logic, shifts/rotates), plus iterative unsigned multiply and divide, under a start/busy/done handshake. Results and a 4-bit flag register are held until the next completed operation. The carry flag feeds ADC/SBB chains. Sits between the register file operand buses and the writeback mux.

Parameters:
TAM, 16, datapath width in bits (>=4).
CW, $clog2(TAM+1), iteration counter width (derived; do not override).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
ULA_start  in  1  request; sampled only when not busy.
ULA_ctrl  in  4  opcode, latched with start.
ULA_A  in  TAM  operand A, latched with start.
ULA_B  in  TAM  operand B, latched with start.
ULA_OUT  out  TAM  result (MUL low half, DIV quotient).
ULA_OUT_HI  out  TAM  MUL high half, DIV remainder; 0 for all other ops.
ULA_flags  out  4  {overflow, minus, zero, carry}, registered.
ULA_busy  out  1  high while MUL/DIV iterates.
ULA_done  out  1  one-cycle pulse; result and flags valid from this cycle.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, counter 0, carry flag 0. Applies mid-operation: iteration aborts, no done pulse, partial result discarded.
- Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A, 7 SHR A (logical), 8 ROL A, 9 ROR A, 10 ADC (A+B+C), 11 SBB (A-B-C), 12 MUL (unsigned, 2*TAM product), 13 DIVU (unsigned), 14 ASR A, 15 PASS B.
- FSM states: IDLE, MUL, DIV.
- IDLE with start=1 and a single-cycle op: result and flags written on that edge; done=1 during the following cycle. Latency is 1.
- IDLE with start=1 and op 12/13: operands are latched, counter=0, state goes to MUL/DIV, and busy=1 from the next cycle.
- MUL is shift-add, one bit per cycle. DIV is restoring, one quotient bit per cycle. Each runs exactly TAM iteration edges.
- On the TAM-th iteration edge: OUT/OUT_HI/flags are written, state returns to IDLE, busy=0, and done=1 for one cycle. Total latency from the start edge to done is TAM+1 cycles.
- start while busy is ignored: no queueing, and latched operands are unaffected. Operand input changes during busy have no effect.
- start in the same cycle as done is accepted normally (back-to-back).
- Outputs hold their values between operations. done is 0 whenever no completion occurs.
- Carry flag:
  - ADD/ADC: carry out.
  - SUB/SBB: borrow (1 when the unsigned result is negative).
  - SHL/ROL: old A[TAM-1].
  - SHR/ROR/ASR: old A[0].
  - MUL: 1 if the high half is nonzero.
  - DIVU: 1 on divide-by-zero.
  - Logic/NOT/PASS: 0.
- Overflow flag: two's-complement overflow for ADD/SUB/ADC/SBB; 0 otherwise.
- Minus flag: ULA_OUT[TAM-1] for all ops, except MUL where it is ULA_OUT_HI[TAM-1].
- Zero flag: ULA_OUT==0, except MUL where it is {HI,OUT}==0.
- Divide by zero: still takes TAM+1 cycles; OUT = all ones, OUT_HI = A, carry=1.
- ADC/SBB use the carry flag value held before the start edge.
- All arithmetic is modulo 2^TAM (2^(2*TAM) for MUL). No X propagation from unused opcode paths.

Test Plan:
- ADD A=0x7FFF, B=0x0001 -> done next cycle; OUT=0x8000, OUT_HI=0, flags {V=1,N=1,Z=0,C=0}.
- ADD 0xFFFF+0x0001 -> OUT=0, Z=1, C=1. Then ADC 0x0001+0x0001 -> OUT=0x0003, C=0. Then SUB 0x0003-0x0005 -> OUT=0xFFFE, N=1, C=1.
- MUL 0x1234*0x0100 -> busy for 16 cycles; done exactly 17 cycles after the start edge; OUT=0x3400, OUT_HI=0x0012, C=1. A second start at cycle 5 is ignored.
- DIVU 100/7 -> OUT=14, OUT_HI=2, C=0. DIVU 0x1234/0 -> OUT=0xFFFF, OUT_HI=0x1234, C=1, latency 17.
- ROL 0x8001 -> 0x0003, C=1. SHR 0x0001 -> 0x0000, Z=1, C=1. ASR 0x8000 -> 0xC000, N=1.
- rst=1 at iteration 5 of MUL -> next cycle busy=0, OUT/OUT_HI/flags=0, no done pulse. A new ADD issued afterwards completes normally.
